// File: rtl/seq_alu_if.sv
// Operand/result bundle between the control unit and the sequential ALU.
// Purely wiring; adds no latency.
// Flow control is the start/busy/done handshake carried here.
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             csel;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             zout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, cin, csel,
    input  y, cout, zout, busy, done
  );

  modport slave (
    input  start, op, a, b, cin, csel,
    output y, cout, zout, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub, bit-serial shifts, shift-add multiply.
// Latency 1 cycle for simple ops, n+1 for a shift by n, WIDTH+1 for multiply.
// start is ignored while busy; nothing is queued, done pulses once per accepted op.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input logic    clk,
  input logic    reset,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_NOT  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_ASR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, MULT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   y_q, y_nxt;
  logic               cout_q, cout_nxt;
  logic               done_q, done_nxt;
  logic [SHW:0]       cnt, cnt_nxt;
  logic [3:0]         sop, sop_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [2*WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [2*WIDTH-1:0] acc, acc_nxt;

  logic               c_sel;
  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   sh_val;
  logic               sh_out;
  logic [2*WIDTH-1:0] acc_step;

  // stored carry lets multi-word add/sub chain through the cout register
  assign c_sel    = bus.csel ? cout_q : bus.cin;
  assign amt      = bus.b[SHW-1:0];
  assign acc_step = mplier[0] ? acc + mcand : acc;

  assign bus.y    = y_q;
  assign bus.cout = cout_q;
  assign bus.zout = (y_q == '0);
  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;

  // one-bit step of the working register for the captured shift kind
  always_comb begin
    sh_val = work;
    sh_out = 1'b0;
    case (sop)
      OP_SHL: begin
        sh_val = {work[WIDTH-2:0], 1'b0};
        sh_out = work[WIDTH-1];
      end
      OP_SHR: begin
        sh_val = {1'b0, work[WIDTH-1:1]};
        sh_out = work[0];
      end
      OP_ASR: begin
        sh_val = {work[WIDTH-1], work[WIDTH-1:1]};
        sh_out = work[0];
      end
      default: begin
        sh_val = work;
        sh_out = 1'b0;
      end
    endcase
  end

  // next-state, datapath loads and result writeback
  always_comb begin
    state_nxt  = state;
    y_nxt      = y_q;
    cout_nxt   = cout_q;
    done_nxt   = 1'b0;
    cnt_nxt    = cnt;
    sop_nxt    = sop;
    work_nxt   = work;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    sum        = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          done_nxt = 1'b1;
          cout_nxt = 1'b0;
          case (bus.op)
            OP_PASS: y_nxt = bus.a;
            OP_NOT:  y_nxt = ~bus.a;
            OP_ADD: begin
              sum      = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, c_sel};
              y_nxt    = sum[WIDTH-1:0];
              cout_nxt = sum[WIDTH];
            end
            OP_SUB: begin
              sum      = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, c_sel};
              y_nxt    = sum[WIDTH-1:0];
              cout_nxt = sum[WIDTH];
            end
            OP_AND:  y_nxt = bus.a & bus.b;
            OP_OR:   y_nxt = bus.a | bus.b;
            OP_XOR:  y_nxt = bus.a ^ bus.b;
            OP_SHL, OP_SHR, OP_ASR: begin
              if (amt == '0) begin
                y_nxt = bus.a;
              end else begin
                done_nxt  = 1'b0;
                cout_nxt  = cout_q;
                work_nxt  = bus.a;
                sop_nxt   = bus.op;
                cnt_nxt   = {1'b0, amt};
                state_nxt = SHIFT;
              end
            end
            OP_MUL: begin
              done_nxt   = 1'b0;
              cout_nxt   = cout_q;
              mcand_nxt  = {{WIDTH{1'b0}}, bus.a};
              mplier_nxt = bus.b;
              acc_nxt    = '0;
              cnt_nxt    = CNT_FULL;
              state_nxt  = MULT;
            end
            default: y_nxt = '0;
          endcase
        end
      end
      SHIFT: begin
        work_nxt = sh_val;
        cnt_nxt  = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          y_nxt     = sh_val;
          cout_nxt  = sh_out;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      MULT: begin
        acc_nxt    = acc_step;
        mcand_nxt  = {mcand[2*WIDTH-2:0], 1'b0};
        mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
        cnt_nxt    = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          y_nxt     = acc_step[WIDTH-1:0];
          cout_nxt  = |acc_step[2*WIDTH-1:WIDTH];
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register; reset discards any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // result, flag and iteration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q    <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
      sop    <= '0;
      work   <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      y_q    <= y_nxt;
      cout_q <= cout_nxt;
      done_q <= done_nxt;
      cnt    <= cnt_nxt;
      sop    <= sop_nxt;
      work   <= work_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, corner sequences, random ops.
// Expected results come from an arithmetic reference model of the op set.
// Latency, one-cycle done pulse and busy behaviour are checked on every op.
module tb_seq_alu;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   e0;
  logic model_c;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         csel;
    logic [W-1:0] ey;
    logic         ec;
  } vec_t;

  vec_t vecs[17];

  // reference: {cout, y} from plain arithmetic on the op definitions
  function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic c);
    int t;
    int n;
    logic [2*W-1:0] p;
    logic signed [W-1:0] sa;
    n  = int'(b) % W;
    sa = a;
    case (op)
      4'd0: return {1'b0, a};
      4'd1: return {1'b0, ~a};
      4'd2: begin
        t = int'(a) + int'(b) + int'(c);
        return (W+1)'(t);
      end
      4'd3: begin
        t = int'(a) - int'(b) - 1 + int'(c);
        return {(t >= 0), W'(t)};
      end
      4'd4: return {1'b0, a & b};
      4'd5: return {1'b0, a | b};
      4'd6: return {1'b0, a ^ b};
      4'd7: return (n == 0) ? {1'b0, a} : {a[W-n], W'(a << n)};
      4'd8: return (n == 0) ? {1'b0, a} : {a[n-1], W'(a >> n)};
      4'd9: return (n == 0) ? {1'b0, a} : {a[n-1], W'(sa >>> n)};
      4'd10: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return {(p[2*W-1:W] != '0), p[W-1:0]};
      end
      default: return '0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [W-1:0] b);
    int n;
    n = int'(b) % W;
    if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && n > 0) return n + 1;
    if (op == 4'd10) return W + 1;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic csel);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.csel  = csel;
    @(posedge clk);
    #1;
    e0        = cyc;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.cin   = ~cin;
  endtask

  task automatic wait_done(output int lat);
    while (!bus.done && (cyc - e0) < 60) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - e0 + 1;
  endtask

  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic csel,
                       input logic [W-1:0] ey, input logic ec);
    int lat;
    int le;
    le = lat_of(op, b);
    launch(op, a, b, cin, csel);
    chk({name, ".busy"}, 32'(bus.busy), 32'(le > 1));
    wait_done(lat);
    chk({name, ".latency"}, 32'(lat), 32'(le));
    chk({name, ".y"}, 32'(bus.y), 32'(ey));
    chk({name, ".cout"}, 32'(bus.cout), 32'(ec));
    chk({name, ".zout"}, 32'(bus.zout), 32'(ey == '0));
    model_c = ec;
    @(posedge clk);
    #1;
    chk({name, ".done_once"}, 32'(bus.done), 32'd0);
    chk({name, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W:0] m;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;
    logic rcin, rcsel, rc;

    vecs[0]  = '{4'd2,  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[1]  = '{4'd2,  16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[2]  = '{4'd3,  16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1};
    vecs[3]  = '{4'd3,  16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0001, 1'b1};
    vecs[4]  = '{4'd3,  16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0};
    vecs[5]  = '{4'd7,  16'h8001, 16'h0004, 1'b0, 1'b0, 16'h0010, 1'b0};
    vecs[6]  = '{4'd9,  16'h8000, 16'h000F, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    vecs[7]  = '{4'd8,  16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[8]  = '{4'd10, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[9]  = '{4'd10, 16'h00FF, 16'h0003, 1'b0, 1'b0, 16'h02FD, 1'b0};
    vecs[10] = '{4'd12, 16'h1234, 16'h5678, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[11] = '{4'd1,  16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hFF00, 1'b0};
    vecs[12] = '{4'd6,  16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 16'hFF00, 1'b0};
    vecs[13] = '{4'd8,  16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b1};
    vecs[14] = '{4'd7,  16'hC000, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[15] = '{4'd2,  16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0};
    vecs[16] = '{4'd0,  16'hA5A5, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 1'b0};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.csel  = 1'b0;
    model_c   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.y", 32'(bus.y), 32'd0);
    chk("reset.cout", 32'(bus.cout), 32'd0);
    chk("reset.zout", 32'(bus.zout), 32'd1);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].csel, vecs[i].ey, vecs[i].ec);
    end

    // start during a multiply is dropped, not queued
    launch(4'd10, 16'h00FF, 16'h0003, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd2;
    bus.a     = 16'h0001;
    bus.b     = 16'h0001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ignore.busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk("ignore.latency", 32'(lat), 32'(W + 1));
    chk("ignore.y", 32'(bus.y), 32'h02FD);
    chk("ignore.cout", 32'(bus.cout), 32'd0);
    @(posedge clk);
    #1;
    chk("ignore.no_queue", 32'(bus.done), 32'd0);
    chk("ignore.idle", 32'(bus.busy), 32'd0);
    model_c = 1'b0;

    // back-to-back single-cycle ops
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd4;
    bus.a     = 16'hF0F0;
    bus.b     = 16'h0FF0;
    @(posedge clk);
    #1;
    chk("b2b.and_done", 32'(bus.done), 32'd1);
    chk("b2b.and_y", 32'(bus.y), 32'h00F0);
    bus.op = 4'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b.or_done", 32'(bus.done), 32'd1);
    chk("b2b.or_y", 32'(bus.y), 32'hFFF0);
    @(posedge clk);
    #1;
    chk("b2b.done_low", 32'(bus.done), 32'd0);

    // reset in the middle of a multiply
    do_op("pre_reset", 4'd2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1);
    launch(4'd10, 16'h1234, 16'h5678, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset.y", 32'(bus.y), 32'd0);
    chk("midreset.cout", 32'(bus.cout), 32'd0);
    chk("midreset.zout", 32'(bus.zout), 32'd1);
    chk("midreset.busy", 32'(bus.busy), 32'd0);
    chk("midreset.done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    model_c = 1'b0;
    do_op("post_reset", 4'd2, 16'h0002, 16'h0003, 1'b0, 1'b1, 16'h0005, 1'b0);

    // random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop   = 4'($urandom_range(0, 15));
      ra    = W'($urandom);
      rb    = W'($urandom);
      rcin  = 1'($urandom);
      rcsel = 1'($urandom);
      rc    = rcsel ? model_c : rcin;
      m     = model(rop, ra, rb, rc);
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rcin, rcsel, m[W-1:0], m[W]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
